// File: rtl/set_assoc_cache_ctrl_if.sv
// Requester and backing-memory handshake bundle for set_assoc_cache_ctrl.
// slave = cache controller side, master = requester/memory side.
interface set_assoc_cache_ctrl_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_hit;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_hit,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_hit,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/set_assoc_cache_ctrl.sv
// Write-back, write-allocate set-associative cache controller with true-LRU.
// Define CACHE_STATS_EN to build the saturating hit/miss counters.
module set_assoc_cache_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 4,
  parameter int CNT_W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  set_assoc_cache_ctrl_if.slave bus,
  output logic [CNT_W-1:0]      read_hit,
  output logic [CNT_W-1:0]      read_miss,
  output logic [CNT_W-1:0]      write_hit,
  output logic [CNT_W-1:0]      write_miss
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, RESP} state_t;
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;

  logic [SETS-1:0][WAYS-1:0]             vld_q, dty_q;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q;
  logic [SETS-1:0][WAYS-1:0][DATA_W-1:0] dat_q;
  logic [SETS-1:0][WAYS-1:0][WAY_W-1:0]  age_q;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  rtag;
  logic [WAYS-1:0]   hit_vec;
  logic              hit, vic_found, vic_dirty;
  logic [WAY_W-1:0]  hit_way, vic_way, acc_way, way_q;
  logic              hit_q;
  logic [DATA_W-1:0] rdata_q;

  assign idx  = req_q.addr[IDX_W-1:0];
  assign rtag = req_q.addr[ADDR_W-1:IDX_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = vld_q[idx][w] && (tag_q[idx][w] == rtag);
  end

  // Victim: first invalid way, otherwise the oldest (age WAYS-1).
  always_comb begin
    hit_way   = '0;
    vic_way   = '0;
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++)
      if (hit_vec[w]) hit_way = WAY_W'(w);
    for (int w = 0; w < WAYS; w++)
      if (!vic_found && !vld_q[idx][w]) begin
        vic_way   = WAY_W'(w);
        vic_found = 1'b1;
      end
    if (!vic_found)
      for (int w = 0; w < WAYS; w++)
        if (age_q[idx][w] == WAY_W'(WAYS-1)) vic_way = WAY_W'(w);
  end

  assign hit       = |hit_vec;
  assign acc_way   = hit ? hit_way : vic_way;
  assign vic_dirty = vld_q[idx][vic_way] && dty_q[idx][vic_way];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.mem_rd     = 1'b0;
    bus.mem_wr     = 1'b0;
    bus.mem_addr   = '0;
    bus.mem_wdata  = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (hit)            state_nxt = RESP;
        else if (vic_dirty) state_nxt = WB;
        else if (req_q.we)  state_nxt = RESP;
        else                state_nxt = FILL;
      end
      WB: begin
        bus.mem_wr    = 1'b1;
        bus.mem_addr  = {tag_q[idx][way_q], idx};
        bus.mem_wdata = dat_q[idx][way_q];
        if (bus.mem_ack) state_nxt = req_q.we ? RESP : FILL;
      end
      FILL: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = req_q.addr;
        if (bus.mem_ack) state_nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_hit   = hit_q;

  // Tag/data arrays carry no reset; valid/dirty/age define line state.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      dty_q   <= '0;
      req_q   <= '0;
      way_q   <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age_q[s][w] <= WAY_W'(w);
    end else begin
      case (state)
        IDLE:
          if (bus.req_valid) req_q <= '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
        LOOKUP: begin
          way_q <= acc_way;
          hit_q <= hit;
          // Ages are updated here for misses too: the target way is already fixed.
          for (int w = 0; w < WAYS; w++)
            if (WAY_W'(w) == acc_way)                   age_q[idx][w] <= '0;
            else if (age_q[idx][w] < age_q[idx][acc_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
          if (hit) begin
            if (req_q.we) begin
              dat_q[idx][hit_way] <= req_q.wdata;
              dty_q[idx][hit_way] <= 1'b1;
              rdata_q             <= req_q.wdata;
            end else begin
              rdata_q <= dat_q[idx][hit_way];
            end
          end else if (req_q.we && !vic_dirty) begin
            vld_q[idx][vic_way] <= 1'b1;
            dty_q[idx][vic_way] <= 1'b1;
            tag_q[idx][vic_way] <= rtag;
            dat_q[idx][vic_way] <= req_q.wdata;
            rdata_q             <= req_q.wdata;
          end
        end
        WB:
          if (bus.mem_ack) begin
            if (req_q.we) begin
              tag_q[idx][way_q] <= rtag;
              dat_q[idx][way_q] <= req_q.wdata;
              rdata_q           <= req_q.wdata;
            end else begin
              dty_q[idx][way_q] <= 1'b0;
            end
          end
        FILL:
          if (bus.mem_ack) begin
            vld_q[idx][way_q] <= 1'b1;
            dty_q[idx][way_q] <= 1'b0;
            tag_q[idx][way_q] <= rtag;
            dat_q[idx][way_q] <= bus.mem_rdata;
            rdata_q           <= bus.mem_rdata;
          end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      read_hit   <= '0;
      read_miss  <= '0;
      write_hit  <= '0;
      write_miss <= '0;
    end else if (state == RESP) begin
      case ({req_q.we, hit_q})
        2'b01:   if (read_hit   != '1) read_hit   <= read_hit   + 1'b1;
        2'b00:   if (read_miss  != '1) read_miss  <= read_miss  + 1'b1;
        2'b11:   if (write_hit  != '1) write_hit  <= write_hit  + 1'b1;
        default: if (write_miss != '1) write_miss <= write_miss + 1'b1;
      endcase
    end
  end
`else
  assign read_hit   = '0;
  assign read_miss  = '0;
  assign write_hit  = '0;
  assign write_miss = '0;
`endif
endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Scoreboard bench for set_assoc_cache_ctrl: directed requests, a latency-configurable
// memory responder, and a response monitor fed by an expectation queue.
module tb_set_assoc_cache_ctrl;
  localparam int AW = 12, DW = 32, CW = 32;

  typedef struct { logic [DW-1:0] rdata; bit hit; int lat; } rexp_t;
  typedef struct { bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [CW-1:0] read_hit, read_miss, write_hit, write_miss;

  set_assoc_cache_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  set_assoc_cache_ctrl #(.ADDR_W(AW), .DATA_W(DW), .SETS(8), .WAYS(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .read_hit(read_hit), .read_miss(read_miss), .write_hit(write_hit), .write_miss(write_miss)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int mem_lat = 2;
  rexp_t resp_q[$];
  int    acc_q[$];
  mexp_t mem_q[$];
  logic [DW-1:0] mem [0:4095];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endfunction

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (resp_q.size() == 0 || acc_q.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          rexp_t e;
          int a;
          e = resp_q.pop_front();
          a = acc_q.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_hit", bus.resp_hit, e.hit);
          if (e.lat >= 0) chk("resp_latency", cyc - a, e.lat);
        end
      end
    end
  end

  // Memory responder
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_rd && bus.mem_wr) chk("mem_rd_wr_exclusive", 1, 0);
      if (bus.mem_rd || bus.mem_wr) begin
        if (mem_q.size() == 0) begin
          chk("unexpected_mem_traffic", {bus.mem_wr, bus.mem_addr}, 0);
        end else begin
          mexp_t m;
          m = mem_q.pop_front();
          chk("mem_kind", bus.mem_wr, m.wr);
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.wr) chk("mem_wdata", bus.mem_wdata, m.data);
        end
        repeat (mem_lat) @(negedge clk);
        if (bus.mem_rd || bus.mem_wr) begin
          if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = mem[bus.mem_addr];
          bus.mem_ack = 1'b1;
          @(negedge clk);
          bus.mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    int t = 0;
    while (resp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (resp_q.size() != 0) begin
      chk("resp_timeout", resp_q.size(), 0);
      resp_q.delete();
      acc_q.delete();
    end
  endtask

  task automatic do_req(bit we, logic [AW-1:0] a, logic [DW-1:0] d,
                        logic [DW-1:0] er, bit eh, int el);
    int t = 0;
    resp_q.push_back('{rdata: er, hit: eh, lat: el});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    while (!bus.req_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    acc_q.push_back(cyc);
    @(negedge clk);
    bus.req_valid = 1'b0;
    drain();
  endtask

  task automatic exp_mem(bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    mem_q.push_back('{wr: wr, addr: a, data: d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_mem_rd_wr", {bus.mem_rd, bus.mem_wr}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
  endtask

  task automatic chk_cnt(int rh, int rm, int wh, int wm);
`ifdef CACHE_STATS_EN
    chk("cnt_read_hit", read_hit, rh);
    chk("cnt_read_miss", read_miss, rm);
    chk("cnt_write_hit", write_hit, wh);
    chk("cnt_write_miss", write_miss, wm);
`else
    chk("cnt_read_hit", read_hit, 0);
    chk("cnt_read_miss", read_miss, 0);
    chk("cnt_write_hit", write_hit, 0);
    chk("cnt_write_miss", write_miss, 0);
    if (rh + rm + wh + wm < 0) chk("cnt_args", 0, 1);
`endif
  endtask

  task automatic chk_mem_drained(string nm);
    chk(nm, mem_q.size(), 0);
    mem_q.delete();
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 32'h5000_0000 | i;
    mem[12'h010] = 32'hDEAD_BEEF;

    // Read miss then hit
    do_reset();
    chk_cnt(0, 0, 0, 0);
    exp_mem(0, 12'h010, 0);
    do_req(0, 12'h010, 0, 32'hDEAD_BEEF, 0, -1);
    do_req(0, 12'h010, 0, 32'hDEAD_BEEF, 1, 2);
    chk_mem_drained("s1_mem_done");
    chk_cnt(1, 1, 0, 0);

    // Clean write miss allocates without memory traffic
    do_reset();
    do_req(1, 12'h028, 32'h1234_5678, 32'h1234_5678, 0, 2);
    do_req(0, 12'h028, 0, 32'h1234_5678, 1, 2);
    do_req(1, 12'h028, 32'h0BAD_F00D, 32'h0BAD_F00D, 1, 2);
    do_req(0, 12'h028, 0, 32'h0BAD_F00D, 1, 2);
    chk_mem_drained("s2_mem_done");
    chk_cnt(2, 0, 1, 1);

    // LRU replacement in set 0
    do_reset();
    exp_mem(0, 12'h000, 0); do_req(0, 12'h000, 0, 32'h5000_0000, 0, -1);
    exp_mem(0, 12'h008, 0); do_req(0, 12'h008, 0, 32'h5000_0008, 0, -1);
    exp_mem(0, 12'h010, 0); do_req(0, 12'h010, 0, 32'hDEAD_BEEF, 0, -1);
    exp_mem(0, 12'h018, 0); do_req(0, 12'h018, 0, 32'h5000_0018, 0, -1);
    do_req(0, 12'h000, 0, 32'h5000_0000, 1, 2);
    exp_mem(0, 12'h020, 0); do_req(0, 12'h020, 0, 32'h5000_0020, 0, -1);
    exp_mem(0, 12'h008, 0); do_req(0, 12'h008, 0, 32'h5000_0008, 0, -1);
    do_req(0, 12'h000, 0, 32'h5000_0000, 1, 2);
    chk_mem_drained("s3_mem_done");
    chk_cnt(2, 6, 0, 0);

    // Dirty evictions in set 1
    do_reset();
    do_req(1, 12'h001, 32'hA0, 32'hA0, 0, 2);
    do_req(1, 12'h009, 32'hA1, 32'hA1, 0, 2);
    do_req(1, 12'h011, 32'hA2, 32'hA2, 0, 2);
    do_req(1, 12'h019, 32'hA3, 32'hA3, 0, 2);
    exp_mem(1, 12'h001, 32'hA0);
    exp_mem(0, 12'h021, 0);
    do_req(0, 12'h021, 0, 32'h5000_0021, 0, -1);
    exp_mem(1, 12'h009, 32'hA1);
    exp_mem(0, 12'h001, 0);
    do_req(0, 12'h001, 0, 32'hA0, 0, -1);
    exp_mem(1, 12'h011, 32'hA2);
    do_req(1, 12'h041, 32'hB0, 32'hB0, 0, -1);
    do_req(0, 12'h041, 0, 32'hB0, 1, 2);
    chk_mem_drained("s4_mem_done");
    chk_cnt(1, 2, 0, 5);

    // Reset while a fill is outstanding
    do_reset();
    mem_lat = 6;
    exp_mem(0, 12'h030, 0);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 12'h030;
    @(negedge clk);
    bus.req_valid = 1'b0;
    begin
      int t = 0;
      while (!bus.mem_rd && t < 20) begin
        @(negedge clk);
        t++;
      end
      chk("s5_fill_started", bus.mem_rd, 1);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("s5_mem_rd_dropped", bus.mem_rd, 0);
    chk("s5_req_ready", bus.req_ready, 1);
    chk_cnt(0, 0, 0, 0);
    repeat (12) @(negedge clk);
    mem_lat = 2;
    chk_mem_drained("s5_fill_consumed");
    exp_mem(0, 12'h010, 0);
    do_req(0, 12'h010, 0, 32'hDEAD_BEEF, 0, -1);
    chk_mem_drained("s5_mem_done");
    chk_cnt(0, 1, 0, 0);

    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
